// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle memory access sequencer for the LC-3b datapath.
// Takes one load/store request at a time, drives the word-addressed memory
// port until mem_resp, then formats read data for the MDR with a one-cycle
// load strobe and signals completion with a one-cycle done pulse.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that waits
// TIMEOUT cycles for mem_resp (done with err=1, no MDR load).
module mem_access_ctrl #(
    parameter int width   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [width-1:0] req_addr,
    input  logic [width-1:0] req_wdata,
    output logic [width-1:0] mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_wmask,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic             mdr_load,
    output logic [width-1:0] mdr_d,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WRITE    = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] addr_q;
    logic [width-1:0] wdata_q;
    logic [1:0]       wmask_q;
    logic             write_q;
    logic             byte_q;
    logic             handshake;
    logic             timeout_hit;
    logic [width-1:0] wdata_fmt;
    logic [7:0]       rbyte;
    logic [width-1:0] rdata_fmt;

    assign handshake = req_valid && req_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Wait counter: cleared when an access starts, counts cycles spent waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (handshake) begin
            wait_cnt <= '0;
        end else if (state == READ || state == WRITE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The limit is reached at the edge that would make the count TIMEOUT;
    // a response arriving at that same edge takes priority over the abort.
    assign timeout_hit = (state == READ || state == WRITE) && !mem_resp &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Abort flag: remembers that the current access ended by timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (handshake) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err      = (state == COMPLETE) && err_q;
    assign mdr_load = (state == COMPLETE) && !write_q && !err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign mdr_load    = (state == COMPLETE) && !write_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so ordering between always_ff blocks never matters.
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment up front means no path leaves state_nxt
        // unassigned, which is what prevents a latch from being inferred.
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = req_write ? WRITE : READ;
            READ:     if (mem_resp || timeout_hit) state_nxt = COMPLETE;
            WRITE:    if (mem_resp || timeout_hit) state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Store data formatting: a byte store replicates the byte on both lanes.
    always_comb begin
        wdata_fmt = req_wdata;
        if (req_byte) begin
            wdata_fmt[15:0] = {req_wdata[7:0], req_wdata[7:0]};
        end
    end

    // Request capture at the handshake; these registers drive the memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 2'b00;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
        end else if (handshake) begin
            addr_q  <= req_addr;
            wdata_q <= wdata_fmt;
            wmask_q <= !req_byte ? 2'b11 : (req_addr[0] ? 2'b10 : 2'b01);
            write_q <= req_write;
            byte_q  <= req_byte;
        end
    end

    // Load data formatting: byte loads pick the lane by addr[0] and sign-extend.
    always_comb begin
        rbyte     = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        rdata_fmt = mem_rdata;
        if (byte_q) begin
            rdata_fmt = {{(width - 8){rbyte[7]}}, rbyte};
        end
    end

    // MDR data register: only updated when a read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr_d <= '0;
        end else if (state == READ && mem_resp) begin
            mdr_d <= rdata_fmt;
        end
    end

    // Port outputs are decoded from state or taken straight from registers.
    assign req_ready   = (state == IDLE);
    assign mem_read    = (state == READ);
    assign mem_write   = (state == WRITE);
    assign mem_wmask   = (state == WRITE) ? wmask_q : 2'b00;
    assign mem_address = {addr_q[width-1:1], 1'b0};
    assign mem_wdata   = wdata_q;
    assign done        = (state == COMPLETE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (width=16). Expected completions are
// queued when a request is driven and compared when done pulses.
// Timeout scenarios run when MEM_TIMEOUT_EN is defined (TIMEOUT=4 then).
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 64;
`endif

    typedef struct {
        logic        load;
        logic [15:0] mdr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        mdr_load;
    logic [15:0] mdr_d;
    logic        done;
    logic        err;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [15:0] model_mdr = '0;

    mem_access_ctrl #(.width(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .mdr_load(mdr_load), .mdr_d(mdr_d),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the COMPLETE cycle: pop the oldest expectation and compare.
    task automatic check_completion(input string tag);
        exp_t e;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_mdr_load"}, mdr_load, e.load);
            check({tag, "_mdr_d"}, mdr_d, e.mdr);
            check({tag, "_err"}, err, e.err);
        end
    endtask

    // One complete access; delay = idle cycles before mem_resp, no_resp = let it time out.
    task automatic access(input string tag, input logic wr, input logic bt,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int delay, input bit no_resp);
        exp_t        e;
        logic [7:0]  sel;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_mask;
        int          n;
        if (!wr && !no_resp) begin
            sel       = addr[0] ? rdata[15:8] : rdata[7:0];
            model_mdr = bt ? {{8{sel[7]}}, sel} : rdata;
        end
        e.load    = !wr && !no_resp;
        e.mdr     = model_mdr;
        e.err     = no_resp;
        exp_wdata = bt ? {wdata[7:0], wdata[7:0]} : wdata;
        exp_mask  = bt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;

        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_ready"}, req_ready, 1'b1);

        req_valid = 1'b1;
        req_write = wr;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
        sb.push_back(e);
        step();
        req_valid = 1'b0;

        check({tag, "_mem_read"}, mem_read, !wr);
        check({tag, "_mem_write"}, mem_write, wr);
        check({tag, "_mem_address"}, mem_address, {addr[15:1], 1'b0});
        check({tag, "_mdr_load_busy"}, mdr_load, 1'b0);
        check({tag, "_ready_busy"}, req_ready, 1'b0);
        if (wr) begin
            check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_mem_wmask"}, mem_wmask, exp_mask);
        end else begin
            check({tag, "_mem_wmask_rd"}, mem_wmask, 2'b00);
        end

        if (no_resp) begin
            repeat (TO - 1) begin
                step();
                check({tag, "_strobe_held"}, mem_read | mem_write, 1'b1);
            end
            step();
        end else begin
            repeat (delay) begin
                step();
                check({tag, "_strobe_held"}, mem_read | mem_write, 1'b1);
            end
            mem_resp  = 1'b1;
            mem_rdata = rdata;
            step();
            mem_resp  = 1'b0;
            mem_rdata = 16'hDEAD;
        end

        check_completion(tag);
        check({tag, "_strobes_low"}, {mem_read, mem_write, mem_wmask}, 4'b0000);
        step();
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_ready_again"}, req_ready, 1'b1);
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc;
        int  dn;
        int  last;
        logic hs;

        // Reset values while reset is held.
        #3;
        check("rst_ready", req_ready, 1'b1);
        check("rst_strobes", {mem_read, mem_write, mdr_load, done, err}, 5'b0);
        check("rst_wmask", mem_wmask, 2'b00);
        check("rst_data", {mem_address, mem_wdata, mdr_d}, 48'h0);
        #9 rst_n = 1'b1;
        step();

        // Word read with odd address, response after two cycles.
        access("word_read", 1'b0, 1'b0, 16'h3001, 16'h0000, 16'hBEEF, 2, 1'b0);
        check("word_read_value", mdr_d, 16'hBEEF);

        // Byte reads: odd address selects the high lane, sign-extended.
        access("byte_read_hi", 1'b0, 1'b1, 16'h4001, 16'h0000, 16'h80FF, 0, 1'b0);
        check("byte_read_hi_value", mdr_d, 16'hFF80);
        access("byte_read_lo", 1'b0, 1'b1, 16'h4000, 16'h0000, 16'h807F, 1, 1'b0);
        check("byte_read_lo_value", mdr_d, 16'h007F);

        // Writes: mdr_d must hold the last read value throughout.
        access("byte_write_hi", 1'b1, 1'b1, 16'h5001, 16'h12AB, 16'h0000, 1, 1'b0);
        access("byte_write_lo", 1'b1, 1'b1, 16'h6000, 16'h3455, 16'h0000, 0, 1'b0);
        access("word_write", 1'b1, 1'b0, 16'h5003, 16'hCAFE, 16'h0000, 3, 1'b0);
        check("write_keeps_mdr", mdr_d, 16'h007F);

        // Reset asserted in the middle of a read.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h1234;
        step();
        req_valid = 1'b0;
        check("rst_mid_reading", mem_read, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_read_drop", mem_read, 1'b0);
        check("rst_mid_no_done", done, 1'b0);
        check("rst_mid_ready", req_ready, 1'b1);
        model_mdr = '0;
        step();
        check("rst_mid_no_done_later", done, 1'b0);
        #2 rst_n = 1'b1;
        step();
        access("after_reset", 1'b0, 1'b0, 16'h2222, 16'h0000, 16'h5A5A, 1, 1'b0);

        // Back-to-back: req_valid held high, mem_resp always asserted.
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{load: 1'b0, mdr: model_mdr, err: 1'b0});
        end
        acc       = 0;
        dn        = 0;
        last      = -1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h7000;
        req_wdata = 16'h1111;
        mem_resp  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hs = req_valid && req_ready;
            step();
            if (hs) begin
                acc++;
                if (acc == 3) req_valid = 1'b0;
            end
            if (done) begin
                check_completion("b2b");
                if (dn > 0) check("b2b_spacing", c - last, 3);
                last = c;
                dn++;
            end
        end
        mem_resp = 1'b0;
        check("b2b_accepts", acc, 3);
        check("b2b_done_count", dn, 3);
        check("b2b_sb_drained", sb.size(), 0);

`ifdef MEM_TIMEOUT_EN
        // No response: abort after TIMEOUT cycles with err and no MDR load.
        access("timeout_read", 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 0, 1'b1);
        access("timeout_write", 1'b1, 1'b0, 16'h0200, 16'h4321, 16'h0000, 0, 1'b1);
        // Response arriving at the limit edge completes normally.
        access("resp_at_limit", 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0F0F, TO - 1, 1'b0);
`else
        // Long wait without timeout logic still completes normally.
        access("long_wait", 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0F0F, 10, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access sequencer for the LC-3b datapath. Accepts one read or write request at a time from the control/datapath side, drives the word-addressed memory port, and waits for `mem_resp`. Formats read data (word, or sign-extended byte for LDB) and hands it to the downstream MDR `flipflop_positive` as a one-cycle load strobe plus data.

## Interface
Parameters:
- `width`, 16, datapath/address width; must be even and ≥ 16
- `TIMEOUT`, 64, cycles to wait for `mem_resp` before aborting; used only with `MEM_TIMEOUT_EN`

Ports:
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `req_valid` in 1, request present
- `req_ready` out 1, request accepted when `req_valid && req_ready` at a clock edge
- `req_write` in 1, 1 = store, 0 = load
- `req_byte` in 1, 1 = byte access (LDB/STB), 0 = word
- `req_addr` in width, byte address
- `req_wdata` in width, store data; byte stores use `[7:0]`
- `mem_address` out width, word-aligned address
- `mem_read` out 1, read strobe, held until response
- `mem_write` out 1, write strobe, held until response
- `mem_wmask` out 2, byte-lane enables
- `mem_wdata` out width, write data
- `mem_rdata` in width, read data, valid with `mem_resp`
- `mem_resp` in 1, memory completion
- `mdr_load` out 1, one-cycle load strobe to MDR
- `mdr_d` out width, formatted read data
- `done` out 1, one-cycle completion pulse (read or write)
- `err` out 1, timeout abort flag, valid with `done`

## Operation
- States: IDLE, READ, WRITE, COMPLETE. All outputs registered or decoded from state only.
- IDLE: `req_ready`=1. On handshake, capture addr/wdata/write/byte and go to WRITE (`req_write`=1) or READ.
- READ: `mem_read`=1, `mem_address`={addr[width-1:1],1'b0}. On `mem_resp`, capture formatted data into `mdr_d` and go to COMPLETE.
- WRITE: `mem_write`=1. Word: `mem_wmask`=2'b11, `mem_wdata`=wdata. Byte: `mem_wdata`={wdata[7:0],wdata[7:0]}, `mem_wmask`= addr[0] ? 2'b10 : 2'b01. On `mem_resp`, go to COMPLETE.
- `mem_wmask`=0 outside WRITE.
- Read formatting:
  - Word: `mem_rdata` unchanged; addr[0] ignored.
  - Byte: select `[7:0]` if addr[0]=0, else `[15:8]`, sign-extended to width.
- COMPLETE: `done`=1 for one cycle, `mdr_load`=1 only if the access was a read. Next state IDLE unconditionally.
- `mdr_d` holds its last value except when updated in READ.
- `mem_resp` is ignored in IDLE and COMPLETE.
- Reset values: state IDLE, `req_ready`=1, `mem_read`=`mem_write`=`mdr_load`=`done`=`err`=0, `mem_wmask`=0, `mem_address`=`mem_wdata`=`mdr_d`=0.
- Reset asserted mid-access: immediate return to IDLE, strobes dropped, no `done`.

## Timing
- Handshake at edge E0: `mem_read`/`mem_write` high from E0 until the edge at which `mem_resp` is sampled (Ek).
- `done`/`mdr_load` high for the cycle after Ek.
- `req_ready` high again after Ek+1.
- Minimum turnaround, `mem_resp` in the first cycle: 3 cycles request-to-request.
- Back-to-back requests: `req_valid` held high is next accepted at the first IDLE edge; no request is lost or duplicated.
- `mdr_load` is never asserted in the same cycle as `mem_read`.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to READ/WRITE and increments each cycle there.
  - When it reaches TIMEOUT without `mem_resp`, strobes drop and the state goes to COMPLETE with `err`=1 and `mdr_load`=0.
  - `mem_resp` in the same cycle as the limit wins: normal completion, `err`=0.
- Not defined: no counter; waits indefinitely; `err` tied 0.

## Test plan
- Word read, addr 0x3001, `mem_resp` after 2 cycles with rdata 0xBEEF -> `mem_address`=0x3000, `mdr_d`=0xBEEF, `mdr_load`+`done` one cycle, `err`=0.
- Byte read addr 0x4001, rdata 0x80FF -> `mdr_d`=0xFF80. Byte read addr 0x4000, rdata 0x807F -> `mdr_d`=0x007F.
- Byte write addr 0x5001, wdata 0x12AB -> `mem_wdata`=0xABAB, `mem_wmask`=2'b10; `done` high, `mdr_load` stays 0. Word write -> `mem_wmask`=2'b11.
- `rst_n` low while in READ -> `mem_read` drops asynchronously, no `done`; after release `req_ready`=1 and a new request completes normally.
- `req_valid` held high over 3 requests with immediate `mem_resp` -> exactly 3 `done` pulses, spaced 3 cycles apart.
- `MEM_TIMEOUT_EN` with TIMEOUT=4, no `mem_resp` -> `mem_read` low after 4 cycles, `done`=`err`=1 for one cycle, `mdr_load`=0. Resp on cycle 4 -> `err`=0.
